// File: rtl/fill_sequencer.sv
// Write-side FIFO fill sequencer: writes (num+1) vectors of (size+1) words with an idle gap between vectors.
// Optional XOR checksum of written words is built when FILL_CHECKSUM_EN is defined; otherwise checksum is tied to 0.
module fill_sequencer #(
    parameter int DATA_W     = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        num,
    input  logic [2:0]        size,
    input  logic [2:0]        seed,
    input  logic              wr_full,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              cycle_led,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t     state_reg, state_next;
    logic [2:0] num_reg, num_next;
    logic [2:0] size_reg, size_next;
    logic [2:0] seed_reg, seed_next;
    logic [2:0] vec_reg, vec_next;
    logic [2:0] word_reg, word_next;
    logic [3:0] gap_reg, gap_next;
    logic       led_reg, led_next;
    logic       start_accept;

    assign start_accept = (state_reg == ST_IDLE) && start && !abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            num_reg   <= '0;
            size_reg  <= '0;
            seed_reg  <= '0;
            vec_reg   <= '0;
            word_reg  <= '0;
            gap_reg   <= '0;
            led_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            num_reg   <= num_next;
            size_reg  <= size_next;
            seed_reg  <= seed_next;
            vec_reg   <= vec_next;
            word_reg  <= word_next;
            gap_reg   <= gap_next;
            led_reg   <= led_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        num_next   = num_reg;
        size_next  = size_reg;
        seed_next  = seed_reg;
        vec_next   = vec_reg;
        word_next  = word_reg;
        gap_next   = gap_reg;
        led_next   = led_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_accept) begin
                    state_next = ST_WRITE;
                    num_next   = num;
                    size_next  = size;
                    seed_next  = seed;
                    vec_next   = '0;
                    word_next  = '0;
                    gap_next   = '0;
                end
            end
            ST_WRITE: begin
                // Abort takes priority: the word on the bus this cycle is still taken by the FIFO,
                // but the vector is not counted as completed.
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (!wr_full) begin
                    if (word_reg == size_reg) begin
                        led_next  = ~led_reg;
                        word_next = '0;
                        if (vec_reg == num_reg) begin
                            state_next = ST_DONE;
                        end else if (GAP_CYCLES == 0) begin
                            vec_next = vec_reg + 3'd1;
                        end else begin
                            state_next = ST_GAP;
                            gap_next   = '0;
                        end
                    end else begin
                        word_next = word_reg + 3'd1;
                    end
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (gap_reg == GAP_LAST) begin
                    state_next = ST_WRITE;
                    vec_next   = vec_reg + 3'd1;
                    word_next  = '0;
                end else begin
                    gap_next = gap_reg + 4'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign wr_en     = (state_reg == ST_WRITE) && !wr_full;
    assign busy      = (state_reg == ST_WRITE) || (state_reg == ST_GAP);
    assign done      = (state_reg == ST_DONE);
    assign cycle_led = led_reg;

    always_comb begin
        wr_data      = '0;
        wr_data[8:0] = {seed_reg, vec_reg, word_reg};
    end

`ifdef FILL_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_reg, checksum_next;

    always_comb begin
        checksum_next = checksum_reg;
        if (start_accept) begin
            checksum_next = '0;
        end else if (wr_en) begin
            checksum_next = checksum_reg ^ wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_reg <= '0;
        end else begin
            checksum_reg <= checksum_next;
        end
    end

    assign checksum = checksum_reg;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_fill_sequencer.sv
// Scoreboard bench for fill_sequencer: stimulus pushes the expected word stream, a negedge monitor pops and checks.
module tb_fill_sequencer;

    localparam int DATA_W = 16;
    localparam int GAP    = 2;

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic [2:0]        num;
    logic [2:0]        size;
    logic [2:0]        seed;
    logic              wr_full;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              cycle_led;
    logic [DATA_W-1:0] checksum;

    fill_sequencer #(.DATA_W(DATA_W), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .num       (num),
        .size      (size),
        .seed      (seed),
        .wr_full   (wr_full),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .cycle_led (cycle_led),
        .checksum  (checksum)
    );

    typedef struct {
        logic [DATA_W-1:0] word;
        bit                last;
    } exp_t;

    exp_t              exp_q[$];
    exp_t              mon_e;
    int                n_checks = 0;
    int                n_pass   = 0;
    int                cyc      = 0;
    int                start_cyc = 0;
    int                exp_done_cyc = -1;
    int                last_wr_cyc = 0;
    int                fill_no = 0;
    bit                done_pending = 0;
    bit                done_seen = 0;
    bit                prev_done = 0;
    bit                exp_led = 0;
    logic [DATA_W-1:0] exp_ck = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the fill is just the nested vector/word enumeration of the configuration.
    task automatic start_fill(input logic [2:0] n, input logic [2:0] s, input logic [2:0] sd, input int done_off);
        logic [DATA_W-1:0] ck;
        logic [DATA_W-1:0] wd;
        exp_t              e;
        ck = '0;
        for (int v = 0; v <= int'(n); v++) begin
            for (int w = 0; w <= int'(s); w++) begin
                wd      = '0;
                wd[8:6] = sd;
                wd[5:3] = v[2:0];
                wd[2:0] = w[2:0];
                e.word  = wd;
                e.last  = (w == int'(s));
                exp_q.push_back(e);
                ck ^= wd;
            end
        end
`ifdef FILL_CHECKSUM_EN
        exp_ck = ck;
`else
        exp_ck = '0;
`endif
        num          = n;
        size         = s;
        seed         = sd;
        start        = 1'b1;
        done_pending = 1'b1;
        done_seen    = 1'b0;
        start_cyc    = cyc;
        exp_done_cyc = (done_off < 0) ? -1 : start_cyc + done_off;
        fill_no++;
        tick();
        start = 1'b0;
    endtask

    function automatic int nobp_off(input int n, input int s);
        return (n + 1) * (s + 1) + n * GAP + 1;
    endfunction

    // mode 0: no back-pressure, 1: random back-pressure, 2: full during relative cycles 2..4
    task automatic wait_done(input int mode, input bit poke);
        int rel;
        for (int i = 0; i < 400 && !done_seen; i++) begin
            rel = cyc - start_cyc;
            case (mode)
                1:       wr_full = ($urandom_range(99) < 30);
                2:       wr_full = (rel >= 2 && rel <= 4);
                default: wr_full = 1'b0;
            endcase
            if (poke && rel == 3) begin
                start = 1'b1;
                num   = ~num;
                size  = ~size;
                seed  = ~seed;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        wr_full = 1'b0;
        start   = 1'b0;
        check("done_timeout", {31'd0, done_seen}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (wr_full) check("no_wr_when_full", {31'd0, wr_en}, 32'd0);
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_data", {16'd0, wr_data}, {16'd0, mon_e.word});
                    if (mon_e.last && !abort) exp_led = ~exp_led;
                    last_wr_cyc = cyc;
                end
            end
            if (prev_done) check("done_one_cycle", {31'd0, done}, 32'd0);
            if (done) begin
                check("done_expected", {31'd0, done_pending}, 32'd1);
                done_pending = 1'b0;
                done_seen    = 1'b1;
                check("words_remaining", exp_q.size(), 32'd0);
                check("done_after_last_write", cyc, last_wr_cyc + 1);
                if (exp_done_cyc >= 0) check("done_cycle", cyc, exp_done_cyc);
                check("cycle_led", {31'd0, cycle_led}, {31'd0, exp_led});
                check("checksum", {16'd0, checksum}, {16'd0, exp_ck});
                $display("fill %0d done at cycle %0d (start %0d) led=%0d checksum=0x%0h",
                         fill_no, cyc, start_cyc, cycle_led, checksum);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        num     = '0;
        size    = '0;
        seed    = '0;
        wr_full = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_led", {31'd0, cycle_led}, 32'd0);
        check("rst_wr_data", {16'd0, wr_data}, 32'd0);
        check("rst_checksum", {16'd0, checksum}, 32'd0);
        reset = 1'b1;
        tick();

        // Basic fill: writes in cycles 1-3 and 6-8, done at 9
        start_fill(3'd1, 3'd2, 3'd5, nobp_off(1, 2));
        check("basic_first_wr_en", {31'd0, wr_en}, 32'd1);
        check("basic_busy", {31'd0, busy}, 32'd1);
        wait_done(0, 1'b0);
        check("basic_led_after", {31'd0, cycle_led}, {31'd0, exp_led});

        // Back-pressure window, done at cycle 8
        start_fill(3'd0, 3'd3, 3'd0, 8);
        wait_done(2, 1'b0);

        // Mid-fill start and config change must be ignored
        start_fill(3'd2, 3'd2, 3'd3, nobp_off(2, 2));
        wait_done(0, 1'b1);

        // Abort during a long fill, then restart two cycles later
        start_fill(3'd7, 3'd7, 3'd0, -1);
        while (cyc - start_cyc < 10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_wr_en", {31'd0, wr_en}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_led", {31'd0, cycle_led}, {31'd0, exp_led});
        exp_q.delete();
        done_pending = 1'b0;
        tick();
        start_fill(3'd1, 3'd1, 3'd0, nobp_off(1, 1));
        wait_done(0, 1'b0);

        // Abort together with start in IDLE: stay idle
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_idle_busy", {31'd0, busy}, 32'd0);
        tick();
        check("abort_start_idle_busy2", {31'd0, busy}, 32'd0);

        // Single-word fill
        start_fill(3'd0, 3'd0, 3'd1, nobp_off(0, 0));
        wait_done(0, 1'b0);

        // Randomized fills
        for (int k = 0; k < 24; k++) begin
            logic [2:0] rn;
            logic [2:0] rs;
            logic [2:0] rsd;
            int         md;
            rn  = 3'($urandom_range(7));
            rs  = 3'($urandom_range(7));
            rsd = 3'($urandom_range(7));
            md  = (k % 3 == 0) ? 0 : 1;
            start_fill(rn, rs, rsd, (md == 0) ? nobp_off(int'(rn), int'(rs)) : -1);
            wait_done(md, 1'b0);
            repeat ($urandom_range(2)) tick();
        end

        // Asynchronous reset between edges mid-fill
        start_fill(3'd3, 3'd3, 3'd2, -1);
        repeat (5) tick();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("async_rst_led", {31'd0, cycle_led}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        check("async_rst_checksum", {16'd0, checksum}, 32'd0);
        exp_q.delete();
        done_pending = 1'b0;
        exp_led      = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        start_fill(3'd0, 3'd1, 3'd7, nobp_off(0, 1));
        wait_done(0, 1'b0);

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
